// File: rtl/alu.sv
// alu: 8-bit registered ALU, 16 ops, one-cycle latency.
// Define ALU_DIV_EN to build the op-3 divider; otherwise op 3 yields 8'h00.
module alu (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic [3:0] ALU_Sel,
   output logic [7:0] ALU_Out,
   output logic       CarryOut
);
   logic [7:0]  out_q, out_d, quo;
   logic        carry_q, carry_d;
   logic [8:0]  sum;
   logic [15:0] prod;
   assign sum  = {1'b0, A} + {1'b0, B};
   assign prod = {8'b0, A} * {8'b0, B};
`ifdef ALU_DIV_EN
   assign quo = (B == 8'h00) ? 8'hFF : A / B;
`else
   assign quo = 8'h00;
`endif
   always_comb begin
      out_d   = 8'h00;
      carry_d = sum[8];
      case (ALU_Sel)
         4'd0:  out_d = sum[7:0];
         4'd1:  out_d = A - B;
         4'd2:  out_d = prod[7:0];
         4'd3:  out_d = quo;
         4'd4:  out_d = {A[6:0], 1'b0};
         4'd5:  out_d = {1'b0, A[7:1]};
         4'd6:  out_d = {A[6:0], A[7]};
         4'd7:  out_d = {A[0], A[7:1]};
         4'd8:  out_d = A & B;
         4'd9:  out_d = A | B;
         4'd10: out_d = A ^ B;
         4'd11: out_d = ~(A | B);
         4'd12: out_d = ~(A & B);
         4'd13: out_d = ~(A ^ B);
         4'd14: out_d = {7'b0, A > B};
         default: out_d = {7'b0, A == B};
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q   <= 8'h00;
         carry_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         carry_q <= carry_d;
      end
   end
   assign ALU_Out  = out_q;
   assign CarryOut = carry_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector scoreboard bench for alu.
module tb_alu;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] a = 8'h00, b = 8'h00;
   logic [3:0] sel = 4'h0;
   logic [7:0] alu_out;
   logic       carry_out;
   logic [8:0] exp_q[$];
   int         n_checks = 0;
   int         n_fail = 0;
   logic       stim_done = 1'b0;

   alu dut (
      .clk(clk), .rst(rst), .A(a), .B(b), .ALU_Sel(sel),
      .ALU_Out(alu_out), .CarryOut(carry_out)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic r, input logic [7:0] va, input logic [7:0] vb,
                        input logic [3:0] op, input logic [7:0] eo, input logic ec);
      @(negedge clk);
      rst = r; a = va; b = vb; sel = op;
      exp_q.push_back({ec, eo});
   endtask

   // Monitor: every edge produces a result, so pop one expectation per edge.
   initial begin
      logic [8:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (alu_out !== e[7:0]) begin
               n_fail++;
               $display("FAIL out: sel=%0d a=%h b=%h got %h want %h", sel, a, b, alu_out, e[7:0]);
            end
            n_checks++;
            if (carry_out !== e[8]) begin
               n_fail++;
               $display("FAIL carry: sel=%0d a=%h b=%h got %b want %b", sel, a, b, carry_out, e[8]);
            end
         end
      end
   end

   initial begin
      logic [7:0] sweep [16] = '{8'hFF, 8'hE1, 8'h10,
`ifdef ALU_DIV_EN
                                 8'h10,
`else
                                 8'h00,
`endif
                                 8'hE0, 8'h78, 8'hE1, 8'h78, 8'h00, 8'hFF,
                                 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h00};
      drive(1'b1, 8'h37, 8'hC9, 4'd0, 8'h00, 1'b0);
      drive(1'b1, 8'hFF, 8'hFF, 4'd2, 8'h00, 1'b0);
      for (int i = 0; i < 16; i++)
         drive(1'b0, 8'hF0, 8'h0F, 4'(i), sweep[i], 1'b0);
      drive(1'b0, 8'hFF, 8'h01, 4'd0, 8'h00, 1'b1);
      drive(1'b0, 8'h00, 8'h01, 4'd1, 8'hFF, 1'b0);
`ifdef ALU_DIV_EN
      drive(1'b0, 8'h20, 8'h00, 4'd3, 8'hFF, 1'b0);
      drive(1'b0, 8'hC8, 8'h07, 4'd3, 8'h1C, 1'b0);
`else
      drive(1'b0, 8'h20, 8'h00, 4'd3, 8'h00, 1'b0);
      drive(1'b0, 8'hC8, 8'h07, 4'd3, 8'h00, 1'b0);
`endif
      drive(1'b0, 8'h5A, 8'h5A, 4'd15, 8'h01, 1'b0);
      drive(1'b0, 8'h5A, 8'h5A, 4'd14, 8'h00, 1'b0);
      drive(1'b0, 8'h81, 8'h5A, 4'd6, 8'h03, 1'b0);
      drive(1'b0, 8'h81, 8'h5A, 4'd7, 8'hC0, 1'b0);
      drive(1'b0, 8'h81, 8'h80, 4'd14, 8'h01, 1'b1);
      drive(1'b0, 8'h0C, 8'h0D, 4'd2, 8'h9C, 1'b0);
      drive(1'b0, 8'h80, 8'h80, 4'd8, 8'h80, 1'b1);
      drive(1'b0, 8'hFF, 8'h01, 4'd0, 8'h00, 1'b1);
      drive(1'b1, 8'hFF, 8'h01, 4'd0, 8'h00, 1'b0);
      drive(1'b0, 8'h12, 8'h34, 4'd9, 8'h36, 1'b0);
      stim_done = 1'b1;
   end

   initial begin
      wait (stim_done);
      repeat (3) @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: stimulus did not complete");
      $fatal(1, "timeout");
   end
endmodule
